// File: rtl/imem_loader_if.sv
// Byte-stream input and Imem byte-write bus for the boot-time program loader.
// The loader owns the master side: it consumes the stream and drives the memory writes.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Parses a framed byte stream (sync, 16-bit length, payload, 8-bit checksum) and writes the
// payload to sequential Imem byte addresses from 0. The CPU is held in reset until a frame
// loads and its checksum matches.
module imem_loader #(
  parameter int         ADDR_W    = 12,
  parameter int         MAX_BYTES = 4096,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic           clk,
  input  logic           rst,
  imem_loader_if.master  bus,
  output logic           cpu_hold,
  output logic           done,
  output logic           error
);

  // One extra counter bit lets a full-size payload count past the top address without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [15:0]        len;
  logic [15:0]        len_next;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   counter_next;
  logic [7:0]         csum;
  logic [7:0]         csum_next;
  logic               hold_next;
  logic               done_next;
  logic               error_next;
  logic               accept;
  logic [15:0]        full_len;

  assign bus.in_ready  = ~rst;
  assign accept        = bus.in_valid & bus.in_ready;
  assign full_len      = {len[15:8], bus.in_data};
  assign bus.mem_addr  = counter[ADDR_W-1:0];
  assign bus.mem_wdata = bus.in_data;

  // Frame parser: next state, payload bookkeeping, write strobe and the status flags to register.
  always_comb begin
    state_next   = state;
    len_next     = len;
    counter_next = counter;
    csum_next    = csum;
    hold_next    = cpu_hold;
    done_next    = done;
    error_next   = error;
    bus.mem_we   = 1'b0;

    if (accept) begin
      case (state)
        S_IDLE: begin
          if (bus.in_data == SYNC_BYTE) state_next = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_next[15:8] = bus.in_data;
          state_next     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_next[7:0] = bus.in_data;
          csum_next     = '0;
          counter_next  = '0;
          if ((full_len > 16'(MAX_BYTES)) || (full_len[1:0] != 2'b00)) begin
            state_next = S_ERR;
          end else if (full_len == 16'd0) begin
            state_next = S_CSUM;
          end else begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          bus.mem_we   = 1'b1;
          csum_next    = csum + bus.in_data;
          counter_next = counter + 1'b1;
          if (16'(counter) == (len - 16'd1)) state_next = S_CSUM;
        end
        S_CSUM: begin
          state_next = (bus.in_data == csum) ? S_DONE : S_ERR;
        end
        S_DONE, S_ERR: begin
          if (bus.in_data == SYNC_BYTE) state_next = S_LEN_HI;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase

      case (state_next)
        S_DONE: begin
          hold_next  = 1'b0;
          done_next  = 1'b1;
          error_next = 1'b0;
        end
        S_ERR: begin
          hold_next  = 1'b1;
          done_next  = 1'b0;
          error_next = 1'b1;
        end
        S_LEN_HI: begin
          hold_next  = 1'b1;
          done_next  = 1'b0;
          error_next = 1'b0;
        end
        default: begin
          hold_next  = cpu_hold;
          done_next  = done;
          error_next = error;
        end
      endcase
    end
  end

  // State, length, counter, checksum and status flags; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= '0;
      counter  <= '0;
      csum     <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_next;
      len      <= len_next;
      counter  <= counter_next;
      csum     <= csum_next;
      cpu_hold <= hold_next;
      done     <= done_next;
      error    <= error_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level stimulus with a scoreboard of expected
// writes and status, an Imem byte array fed by the write strobe, and literal spot checks.
module tb_imem_loader;

  localparam int ADDR_W = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_hold;
  logic       done;
  logic       error;

  int         tests_run = 0;
  int         fails     = 0;

  logic       exp_we    = 1'b0;
  int         exp_addr  = 0;
  logic [7:0] exp_wdata = 8'h00;
  logic       exp_hold  = 1'b1;
  logic       exp_done  = 1'b0;
  logic       exp_error = 1'b0;

  logic [7:0] imem [0:4095];
  int         we_count = 0;
  logic [7:0] pay [$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .MAX_BYTES(4096),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Imem model: captures every strobed byte on the next posedge
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      imem[bus.mem_addr] = bus.mem_wdata;
      we_count++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare of DUT outputs against the scoreboard, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (exp_we) begin
        checkOutput("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
      end
      checkOutput("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
      checkOutput("done", 32'(done), 32'(exp_done));
      checkOutput("error", 32'(error), 32'(exp_error));
    end
  end

  function automatic logic [7:0] pay_sum();
    logic [7:0] s = 8'h00;
    foreach (pay[i]) s += pay[i];
    return s;
  endfunction

  task automatic set_exp(input logic h, input logic d, input logic e);
    exp_hold  = h;
    exp_done  = d;
    exp_error = e;
  endtask

  // Present one stream cycle and the write it must produce, then step past the edge
  task automatic drive(input logic [7:0] b, input logic v, input logic we, input int addr);
    bus.in_valid = v;
    bus.in_data  = b;
    exp_we       = we;
    exp_addr     = addr;
    exp_wdata    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    exp_we       = 1'b0;
  endtask

  // Send a whole frame built from pay[]; csum_adj corrupts the checksum byte when nonzero
  task automatic applyStimulus(input logic [15:0] flen, input logic [7:0] csum_adj, input bit toggle);
    logic [7:0] ck;
    drive(8'hA5, 1'b1, 1'b0, 0);
    set_exp(1'b1, 1'b0, 1'b0);
    drive(flen[15:8], 1'b1, 1'b0, 0);
    drive(flen[7:0], 1'b1, 1'b0, 0);
    if ((int'(flen) > 4096) || (flen[1:0] != 2'b00)) begin
      set_exp(1'b1, 1'b0, 1'b1);
      idle();
      return;
    end
    for (int i = 0; i < int'(flen); i++) begin
      drive(pay[i], 1'b1, 1'b1, i);
      if (toggle) drive(8'h5A, 1'b0, 1'b0, 0);
    end
    ck = pay_sum() + csum_adj;
    drive(ck, 1'b1, 1'b0, 0);
    if (csum_adj == 8'h00) set_exp(1'b0, 1'b1, 1'b0);
    else set_exp(1'b1, 1'b0, 1'b1);
    checkOutput("hold_at_csum_edge", 32'(cpu_hold), (csum_adj == 8'h00) ? 32'd0 : 32'd1);
    idle();
  endtask

  task automatic load_program();
    logic [31:0] prog [13];
    prog = '{32'h200900C8, 32'h212AFF9C, 32'h012A5820, 32'h016A6022, 32'h0189682A,
             32'h11A00002, 32'h000B7040, 32'h01C97825, 32'hAC0F0000, 32'h8C180000,
             32'h03095824, 32'h216B0004, 32'h000B6080};
    pay.delete();
    for (int w = 0; w < 13; w++)
      for (int k = 3; k >= 0; k--) pay.push_back(prog[w][8*k +: 8]);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);

    // Junk in IDLE, then an empty frame
    w0 = we_count;
    drive(8'h00, 1'b1, 1'b0, 0);
    drive(8'hFF, 1'b1, 1'b0, 0);
    drive(8'h3C, 1'b1, 1'b0, 0);
    pay.delete();
    applyStimulus(16'd0, 8'h00, 1'b0);
    checkOutput("t6_no_writes", 32'(we_count - w0), 32'd0);
    checkOutput("t6_done", 32'(done), 32'd1);

    // 13-word sample program
    load_program();
    w0 = we_count;
    applyStimulus(16'd52, 8'h00, 1'b0);
    checkOutput("t1_writes", 32'(we_count - w0), 32'd52);
    checkOutput("t1_mem0", 32'(imem[0]), 32'h20);
    checkOutput("t1_mem1", 32'(imem[1]), 32'h09);
    checkOutput("t1_mem2", 32'(imem[2]), 32'h00);
    checkOutput("t1_mem3", 32'(imem[3]), 32'hC8);
    checkOutput("t1_mem7", 32'(imem[7]), 32'h9C);
    checkOutput("t1_mem51", 32'(imem[51]), 32'h80);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_hold", 32'(cpu_hold), 32'd0);

    // Bad checksum, then a good reload
    applyStimulus(16'd52, 8'h01, 1'b0);
    checkOutput("t2_error", 32'(error), 32'd1);
    checkOutput("t2_done", 32'(done), 32'd0);
    checkOutput("t2_hold", 32'(cpu_hold), 32'd1);
    applyStimulus(16'd52, 8'h00, 1'b0);
    checkOutput("t2_reload_done", 32'(done), 32'd1);
    checkOutput("t2_reload_error", 32'(error), 32'd0);

    // Illegal lengths
    w0 = we_count;
    applyStimulus(16'h0006, 8'h00, 1'b0);
    checkOutput("t3_len6_error", 32'(error), 32'd1);
    applyStimulus(16'h1004, 8'h00, 1'b0);
    checkOutput("t3_len4100_error", 32'(error), 32'd1);
    checkOutput("t3_no_writes", 32'(we_count - w0), 32'd0);

    // Gapped payload
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    checkOutput("t4_model_sum", 32'(pay_sum()), 32'hAA);
    w0 = we_count;
    applyStimulus(16'd4, 8'h00, 1'b1);
    checkOutput("t4_writes", 32'(we_count - w0), 32'd4);
    checkOutput("t4_mem0", 32'(imem[0]), 32'h11);
    checkOutput("t4_mem3", 32'(imem[3]), 32'h44);
    checkOutput("t4_done", 32'(done), 32'd1);

    // Reset in the middle of a payload
    load_program();
    drive(8'hA5, 1'b1, 1'b0, 0);
    set_exp(1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0, 0);
    drive(8'h34, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) drive(pay[i], 1'b1, 1'b1, i);
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_hold", 32'(cpu_hold), 32'd1);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_error", 32'(error), 32'd0);
    checkOutput("t5_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    checkOutput("t5_model_sum", 32'(pay_sum()), 32'h38);
    applyStimulus(16'd4, 8'h00, 1'b0);
    checkOutput("t5_mem0", 32'(imem[0]), 32'hDE);
    checkOutput("t5_mem3", 32'(imem[3]), 32'hEF);
    checkOutput("t5_done", 32'(done), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
